pgm_sound_mailbox: RTL and testbench

Parametrised command/reply mailbox between the 68000 main CPU and the Z80 sound CPU. It replaces the three fixed write-only sound latches with NUM_CH channels. Each channel has a host→sound command FIFO of depth DEPTH and a sound→host reply latch with a valid flag. Per-channel pending/overflow status and a maskable Z80 interrupt are added. Both CPU bus decoders drive it with single-cycle strobes in one clock domain.

---
 rtl/pgm_sound_mailbox.sv | 126 ++++++++++++
 tb/tb_pgm_sound_mailbox.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_sound_mailbox.sv
// rtl/pgm_sound_mailbox.sv - 68000/Z80 command FIFO and reply latch mailbox
module pgm_sound_mailbox #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              fixed_20m_clk,
  input  logic              reset_n,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic [CH_W-1:0]   host_ch,
  input  logic [DATA_W-1:0] host_din,
  output logic [DATA_W-1:0] host_dout,
  output logic [NUM_CH-1:0] host_full,
  output logic [NUM_CH-1:0] host_reply_vld,
  output logic [NUM_CH-1:0] host_ovf,
  input  logic [NUM_CH-1:0] host_ovf_clr,
  input  logic              snd_wr,
  input  logic              snd_rd,
  input  logic [CH_W-1:0]   snd_ch,
  input  logic [DATA_W-1:0] snd_din,
  output logic [DATA_W-1:0] snd_dout,
  output logic [NUM_CH-1:0] snd_pending,
  input  logic [NUM_CH-1:0] snd_irq_mask,
  output logic              snd_irq_n
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int MEM_D = 2 ** PTR_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic [DATA_W-1:0] fifo_mem [NUM_CH][MEM_D];
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [PTR_W-1:0]  wptr     [NUM_CH];
  logic [PTR_W-1:0]  rptr     [NUM_CH];
  logic [DATA_W-1:0] last_cmd [NUM_CH];
  logic [DATA_W-1:0] reply    [NUM_CH];

  logic              host_ch_ok, snd_ch_ok;
  logic [NUM_CH-1:0] full_w, empty_w, push, pop, accept, take, ovf_set, rwr, rrd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign host_ch_ok  = {1'b0, host_ch} < CH_LIMIT;
  assign snd_ch_ok   = {1'b0, snd_ch} < CH_LIMIT;
  assign host_full   = full_w;
  assign snd_pending = ~empty_w;

  always_comb begin
    full_w  = '0;
    empty_w = '0;
    push    = '0;
    pop     = '0;
    accept  = '0;
    take    = '0;
    ovf_set = '0;
    rwr     = '0;
    rrd     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full_w[i]  = (cnt[i] == CNT_MAX);
      empty_w[i] = (cnt[i] == '0);
      push[i]    = host_wr && host_ch_ok && (host_ch == CH_W'(i));
      pop[i]     = snd_rd && snd_ch_ok && (snd_ch == CH_W'(i));
      rwr[i]     = snd_wr && snd_ch_ok && (snd_ch == CH_W'(i));
      rrd[i]     = host_rd && host_ch_ok && (host_ch == CH_W'(i));
      take[i]    = pop[i] && !empty_w[i];
      // a pop in the same cycle frees the slot a push into a full FIFO needs
      accept[i]  = push[i] && (!full_w[i] || pop[i]);
      ovf_set[i] = push[i] && full_w[i] && !pop[i];
    end
  end

  // Storage carries no reset: cnt alone defines what is valid.
  always_ff @(posedge fixed_20m_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i]) fifo_mem[i][wptr[i]] <= host_din;
    end
  end

  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        wptr[i]     <= '0;
        rptr[i]     <= '0;
        last_cmd[i] <= '0;
        reply[i]    <= '0;
      end
      host_reply_vld <= '0;
      host_ovf       <= '0;
      host_dout      <= '0;
      snd_dout       <= '0;
      snd_irq_n      <= 1'b1;
    end else begin
      snd_irq_n <= ~|(snd_pending & snd_irq_mask);
      host_ovf  <= (host_ovf & ~host_ovf_clr) | ovf_set;
      if (host_rd && !host_ch_ok) host_dout <= '1;
      if (snd_rd && !snd_ch_ok) snd_dout <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) wptr[i] <= ptr_inc(wptr[i]);
        if (take[i]) begin
          rptr[i]     <= ptr_inc(rptr[i]);
          last_cmd[i] <= fifo_mem[i][rptr[i]];
          snd_dout    <= fifo_mem[i][rptr[i]];
        end else if (pop[i]) begin
          snd_dout <= last_cmd[i];
        end
        if (accept[i] && !take[i]) cnt[i] <= cnt[i] + CNT_W'(1);
        else if (take[i] && !accept[i]) cnt[i] <= cnt[i] - CNT_W'(1);
        if (rrd[i]) host_dout <= reply[i];
        // a colliding sound write keeps the fresh reply flagged as unread
        if (rwr[i]) begin
          reply[i]          <= snd_din;
          host_reply_vld[i] <= 1'b1;
        end else if (rrd[i]) begin
          host_reply_vld[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pgm_sound_mailbox.sv
// tb/tb_pgm_sound_mailbox.sv - randomized model check of a DEPTH=4 and a DEPTH=1 mailbox
module tb_pgm_sound_mailbox;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       host_wr, host_rd, snd_wr, snd_rd;
  logic [1:0] host_ch, snd_ch;
  logic [7:0] host_din, snd_din;
  logic [2:0] host_ovf_clr, snd_irq_mask;

  logic [7:0] host_dout [2];
  logic [7:0] snd_dout  [2];
  logic [2:0] host_full [2];
  logic [2:0] reply_vld [2];
  logic [2:0] host_ovf  [2];
  logic [2:0] pending   [2];
  logic       irq_n     [2];

  int checks = 0;
  int failures = 0;

  int         mcnt  [2][3];
  int         mhead [2][3];
  logic [7:0] mq    [2][3][16];
  logic [7:0] mlast [2][3];
  logic [7:0] mrep  [2][3];
  bit         mvld  [2][3];
  bit         movf  [2][3];
  logic [7:0] mhd   [2];
  logic [7:0] msd   [2];
  bit         mirq_n[2];

  always #25 clk = ~clk;

  pgm_sound_mailbox #(.NUM_CH(3), .DATA_W(8), .DEPTH(4)) u_dut0 (
    .fixed_20m_clk(clk), .reset_n(reset_n),
    .host_wr(host_wr), .host_rd(host_rd), .host_ch(host_ch), .host_din(host_din),
    .host_dout(host_dout[0]), .host_full(host_full[0]), .host_reply_vld(reply_vld[0]),
    .host_ovf(host_ovf[0]), .host_ovf_clr(host_ovf_clr),
    .snd_wr(snd_wr), .snd_rd(snd_rd), .snd_ch(snd_ch), .snd_din(snd_din),
    .snd_dout(snd_dout[0]), .snd_pending(pending[0]), .snd_irq_mask(snd_irq_mask),
    .snd_irq_n(irq_n[0])
  );

  pgm_sound_mailbox #(.NUM_CH(3), .DATA_W(8), .DEPTH(1)) u_dut1 (
    .fixed_20m_clk(clk), .reset_n(reset_n),
    .host_wr(host_wr), .host_rd(host_rd), .host_ch(host_ch), .host_din(host_din),
    .host_dout(host_dout[1]), .host_full(host_full[1]), .host_reply_vld(reply_vld[1]),
    .host_ovf(host_ovf[1]), .host_ovf_clr(host_ovf_clr),
    .snd_wr(snd_wr), .snd_rd(snd_rd), .snd_ch(snd_ch), .snd_din(snd_din),
    .snd_dout(snd_dout[1]), .snd_pending(pending[1]), .snd_irq_mask(snd_irq_mask),
    .snd_irq_n(irq_n[1])
  );

  function automatic int dep(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        mcnt[d][c] = 0; mhead[d][c] = 0; mlast[d][c] = 8'h00;
        mrep[d][c] = 8'h00; mvld[d][c] = 1'b0; movf[d][c] = 1'b0;
      end
      mhd[d] = 8'h00; msd[d] = 8'h00; mirq_n[d] = 1'b1;
    end
  endtask

  // Pop before push reproduces every same-cycle collision rule of the mailbox.
  task automatic model_step();
    int  hc, sc, dp;
    bit  any;
    hc = int'(host_ch);
    sc = int'(snd_ch);
    for (int d = 0; d < 2; d++) begin
      dp  = dep(d);
      any = 1'b0;
      for (int c = 0; c < 3; c++) if (mcnt[d][c] > 0 && snd_irq_mask[c]) any = 1'b1;
      mirq_n[d] = !any;
      for (int c = 0; c < 3; c++) if (host_ovf_clr[c]) movf[d][c] = 1'b0;
      if (snd_rd) begin
        if (sc < 3) begin
          if (mcnt[d][sc] > 0) begin
            mlast[d][sc] = mq[d][sc][mhead[d][sc]];
            mhead[d][sc] = (mhead[d][sc] + 1) % dp;
            mcnt[d][sc]--;
          end
          msd[d] = mlast[d][sc];
        end else msd[d] = 8'hFF;
      end
      if (host_wr && hc < 3) begin
        if (mcnt[d][hc] < dp) begin
          mq[d][hc][(mhead[d][hc] + mcnt[d][hc]) % dp] = host_din;
          mcnt[d][hc]++;
        end else movf[d][hc] = 1'b1;
      end
      if (host_rd) begin
        if (hc < 3) begin
          mhd[d] = mrep[d][hc];
          mvld[d][hc] = 1'b0;
        end else mhd[d] = 8'hFF;
      end
      if (snd_wr && sc < 3) begin
        mrep[d][sc] = snd_din;
        mvld[d][sc] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [2:0] ef, ev, eo, ep;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        ef[c] = (mcnt[d][c] == dep(d));
        ev[c] = mvld[d][c];
        eo[c] = movf[d][c];
        ep[c] = (mcnt[d][c] > 0);
      end
      check($sformatf("d%0d host_full", d), 32'(host_full[d]), 32'(ef));
      check($sformatf("d%0d reply_vld", d), 32'(reply_vld[d]), 32'(ev));
      check($sformatf("d%0d host_ovf", d), 32'(host_ovf[d]), 32'(eo));
      check($sformatf("d%0d pending", d), 32'(pending[d]), 32'(ep));
      check($sformatf("d%0d host_dout", d), 32'(host_dout[d]), 32'(mhd[d]));
      check($sformatf("d%0d snd_dout", d), 32'(snd_dout[d]), 32'(msd[d]));
      check($sformatf("d%0d irq_n", d), 32'(irq_n[d]), 32'(mirq_n[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    host_wr = 1'b0; host_rd = 1'b0; snd_wr = 1'b0; snd_rd = 1'b0; host_ovf_clr = '0;
  endtask

  task automatic do_push(input logic [1:0] c, input logic [7:0] v);
    host_wr = 1'b1; host_ch = c; host_din = v;
    step();
  endtask

  task automatic do_pop(input logic [1:0] c);
    snd_rd = 1'b1; snd_ch = c;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    mreset();
    check_all();
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    host_wr = 1'b0; host_rd = 1'b0; host_ch = '0; host_din = '0; host_ovf_clr = '0;
    snd_wr = 1'b0; snd_rd = 1'b0; snd_ch = '0; snd_din = '0; snd_irq_mask = '0;
    mreset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    do_pop(2'd0);
    check("rst_pop", 32'(snd_dout[0]), 32'h00);

    for (int k = 1; k <= 5; k++) do_push(2'd1, 8'(8'h11 * k));
    check("full_ch1", 32'(host_full[0][1]), 32'd1);
    check("ovf_ch1", 32'(host_ovf[0][1]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      do_pop(2'd1);
      check("pop_order", 32'(snd_dout[0]), 32'(8'h11 * k));
    end
    do_pop(2'd1);
    check("pop_empty", 32'(snd_dout[0]), 32'h44);
    check("pend_ch1", 32'(pending[0][1]), 32'd0);

    for (int k = 0; k < 4; k++) do_push(2'd0, 8'(8'hA0 + k));
    host_wr = 1'b1; host_ch = 2'd0; host_din = 8'hB0; snd_rd = 1'b1; snd_ch = 2'd0;
    step();
    check("full_pushpop", 32'(snd_dout[0]), 32'hA0);
    check("full_keep", 32'(host_full[0][0]), 32'd1);
    check("full_no_ovf", 32'(host_ovf[0][0]), 32'd0);
    for (int k = 0; k < 4; k++) do_pop(2'd0);
    host_wr = 1'b1; host_ch = 2'd0; host_din = 8'hC0; snd_rd = 1'b1; snd_ch = 2'd0;
    step();
    check("empty_pushpop", 32'(snd_dout[0]), 32'hB0);
    check("empty_pend", 32'(pending[0][0]), 32'd1);
    do_pop(2'd0);
    check("empty_stored", 32'(snd_dout[0]), 32'hC0);

    snd_irq_mask = 3'b011;
    do_push(2'd2, 8'h77);
    check("irq_masked", 32'(irq_n[0]), 32'd1);
    step();
    check("irq_masked2", 32'(irq_n[0]), 32'd1);
    snd_irq_mask = 3'b111;
    step();
    check("irq_unmask", 32'(irq_n[0]), 32'd0);
    do_pop(2'd2);
    check("irq_lag", 32'(irq_n[0]), 32'd0);
    step();
    check("irq_clear", 32'(irq_n[0]), 32'd1);

    snd_wr = 1'b1; snd_ch = 2'd0; snd_din = 8'hA5;
    step();
    check("vld_set", 32'(reply_vld[0][0]), 32'd1);
    host_rd = 1'b1; host_ch = 2'd0;
    step();
    check("reply_rd", 32'(host_dout[0]), 32'hA5);
    check("vld_clr", 32'(reply_vld[0][0]), 32'd0);
    snd_wr = 1'b1; snd_ch = 2'd0; snd_din = 8'h5A; host_rd = 1'b1; host_ch = 2'd0;
    step();
    check("collide_old", 32'(host_dout[0]), 32'hA5);
    check("collide_vld", 32'(reply_vld[0][0]), 32'd1);
    host_rd = 1'b1; host_ch = 2'd0;
    step();
    check("collide_new", 32'(host_dout[0]), 32'h5A);

    do_push(2'd3, 8'h99);
    check("oor_wr", 32'(pending[1]), 32'd0);
    host_rd = 1'b1; host_ch = 2'd3;
    step();
    check("oor_host_rd", 32'(host_dout[1]), 32'hFF);
    do_pop(2'd3);
    check("oor_snd_rd", 32'(snd_dout[1]), 32'hFF);

    host_ovf_clr = 3'b010;
    step();
    check("ovf_clr", 32'(host_ovf[0][1]), 32'd0);

    do_push(2'd0, 8'h12);
    snd_wr = 1'b1; snd_ch = 2'd1; snd_din = 8'h34;
    step();
    do_reset();
    do_pop(2'd0);
    check("rst_mid_pop", 32'(snd_dout[0]), 32'h00);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      host_wr  = ($urandom_range(0, 99) < 60);
      host_rd  = ($urandom_range(0, 99) < 30);
      host_ch  = 2'($urandom_range(0, 3));
      host_din = 8'($urandom);
      snd_wr   = ($urandom_range(0, 99) < 30);
      snd_rd   = ($urandom_range(0, 99) < 45);
      snd_ch   = 2'($urandom_range(0, 3));
      snd_din  = 8'($urandom);
      host_ovf_clr = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 7) == 0) snd_irq_mask = 3'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
